fp_serial_tx: RTL
=================

# fp_serial_tx

Downstream transmit stage for the 12-bit-to-floating-point converter. It accepts each converted value as an 8-bit word {S, E[2:0], F[3:0]} over a valid/ready handshake and buffers up to FIFO_DEPTH words. It shifts each word out on a single asynchronous serial line: 1 start bit, 8 data bits LSB first, 1 stop bit. It sits between the converter output and the board's serial/PMOD pin.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit. Legal range is ≥2.
- FIFO_DEPTH, default 4: buffered words. Must be a power of two, ≥2.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_in  input  1  sign bit from the converter.
- e_in  input  3  exponent from the converter.
- f_in  input  4  mantissa from the converter.
- in_valid  input  1  the word on s_in/e_in/f_in is offered this cycle.
- in_ready  output  1  the FIFO can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.
- level  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

## Operation
- Word packing: word = {s_in, e_in, f_in}. Bit 7 = S, bits 6:4 = E, bits 3:0 = F. Data bits are transmitted bit 0 first.
- Values are transmitted exactly as received. There is no range or rounding check.
- Accept: a word is written when in_valid && in_ready at a clock edge.
- in_ready = (level != FIFO_DEPTH), decoded from the registered level.
  - When the FIFO is full, a write is refused even if a pop happens the same cycle.
  - Refused words are dropped. The upstream must hold in_valid until it sees in_ready.
- FIFO: circular buffer with write/read pointers that wrap modulo FIFO_DEPTH.
  - level = +1 on push only, −1 on pop only, unchanged on a simultaneous push and pop.
- FSM states and transitions:
  - IDLE: tx=1, busy=0. If level≠0, pop the head into a shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shreg[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On its last cycle, frame_done=1.
    - If level≠0 on that cycle, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT−1 and resets to 0 on every state/bit change.
- Bit index: 3-bit counter, 0..7.
- busy = 1 in START, DATA and STOP.
- Empty FIFO plus a push: no bypass. The word is written first and popped on the following edge.

## Timing
- Reset values: tx=1, busy=0, frame_done=0, in_ready=1, level=0. FSM=IDLE, pointers=0, timer=0.
- Reset mid-frame: on the edge where rst=1, the frame is aborted. tx=1 from that edge, and the FIFO contents are discarded.
- A push in the same cycle as rst is ignored.
- Latency, with the FIFO empty and FSM in IDLE:
  - Accept at edge N → level=1 after N.
  - Pop at edge N+1 → tx falls after N+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles, measured from the tx falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the frame_done cycle.
- The pop occurs on the edge that enters START. level drops by 1 on that edge.

## Test plan
- Single word, CLKS_PER_BIT=4: S=1, E=101, F=1010 (word 0xDA), one-cycle valid into an idle block.
  - tx after the start bit is 0,1,0,1,1,0,1,1 then 1, each held 4 cycles.
  - Start bit lasts 4 cycles. busy is high for 40 cycles. One frame_done pulse on cycle 40.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - level reaches 1 after the first pop.
  - The second frame's start bit follows frame_done with zero idle cycles.
  - Total busy time is 80 cycles.
- Full FIFO, FIFO_DEPTH=4: hold in_valid with 6 distinct words while a frame is in progress.
  - in_ready drops when level=4.
  - Exactly 5 words are transmitted: 1 in flight plus 4 buffered, in order.
- Push/pop collision: with level=4, assert in_valid on the STOP→START pop cycle.
  - The word is refused (in_ready=0). level goes to 3.
- Reset mid-frame: assert rst during data bit 3 of frame 0xA5 with 2 words queued.
  - tx=1, busy=0, level=0, in_ready=1 the next cycle. No further frames are sent.
- Idle line: 50 cycles with in_valid=0.
  - tx stays 1, busy stays 0, frame_done stays 0.

Source files
------------

// File: rtl/fp_serial_tx.sv
// Serial transmitter for packed {S,E,F} float words: small FIFO in front of an
// 8N1 shifter (start bit, 8 data bits LSB first, stop bit).
module fp_serial_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_in,
    input  logic [2:0]                  e_in,
    input  logic [3:0]                  f_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           push, pop, bit_end;

    assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));
    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign in_ready = (level != LW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        tx         = 1'b1;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx   = shreg[0];
                busy = 1'b1;
                if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                busy = 1'b1;
                if (bit_end) begin
                    frame_done = 1'b1;
                    if (level != '0) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            // Every state change coincides with bit_end, so this also clears on transitions.
            if (state == IDLE || bit_end) timer <= '0;
            else                          timer <= timer + TW'(1);
            if (state == START)                bit_idx <= '0;
            else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
            if (pop)                           shreg <= mem[rd_ptr];
            else if (state == DATA && bit_end) shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= {s_in, e_in, f_in};
    end
endmodule
